ps2_host_tx: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same two open-drain lines the keyboard receiver listens on. It runs the inhibit / request-to-send sequence, shifts out data, parity and stop on the device-generated clock, checks the device acknowledge, and reports done or error. The receiver must ignore the lines while TX_BUSY is high. Tri-state pads live at top level: pad = OE ? 0 : 'z.

---
 rtl/ps2_host_tx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts the frame out on the
// device-generated clock, checks the device acknowledge and reports done/error.
// Pads are open-drain at top level: pad = OE ? 1'b0 : 1'bz.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES     = 10000,
  parameter int REQ_SETUP_CYCLES   = 100,
  parameter int FIRST_EDGE_TIMEOUT = 1500000,
  parameter int BIT_TIMEOUT        = 200000,
  parameter int FILTER_LEN         = 8
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       PS2_CLK_I,
  input  logic       PS2_DATA_I,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int T_A   = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int T_B   = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT : BIT_TIMEOUT;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] REQ_LAST   = TMR_W'(REQ_SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] FIRST_LAST = TMR_W'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BIT_LAST   = TMR_W'(BIT_TIMEOUT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  // synchronizer and filter state
  logic             clk_p0, clk_p1, dat_p0, dat_p1;
  logic             clk_flt, dat_flt, clk_fall;
  logic [FLT_W-1:0] clk_fcnt, dat_fcnt;

  // control state
  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       edge_q, edge_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             nack_q, nack_d;
  logic             load_frame;
  logic [9:0]       frame_q;

  // Stage p0/p1: two-flop synchronizers for the asynchronous pad inputs (idle high)
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= PS2_CLK_I;
      clk_p1 <= clk_p0;
      dat_p0 <= PS2_DATA_I;
      dat_p1 <= dat_p0;
    end
  end

  // Clock filter: accept a new level after FILTER_LEN equal samples; flag 1->0 acceptance as a falling edge
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      clk_flt  <= 1'b1;
      clk_fcnt <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_p1 == clk_flt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FLT_LAST) begin
        clk_flt  <= clk_p1;
        clk_fcnt <= '0;
        clk_fall <= ~clk_p1;
      end else begin
        clk_fcnt <= clk_fcnt + FLT_W'(1);
      end
    end
  end

  // Data filter: same acceptance rule so data and clock share the same latency
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      dat_flt  <= 1'b1;
      dat_fcnt <= '0;
    end else begin
      if (dat_p1 == dat_flt) begin
        dat_fcnt <= '0;
      end else if (dat_fcnt == FLT_LAST) begin
        dat_flt  <= dat_p1;
        dat_fcnt <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + FLT_W'(1);
      end
    end
  end

  // Frame latch: stop, odd parity, data; shifted out LSB first
  always_ff @(posedge CLK) begin
    if (load_frame) frame_q <= {1'b1, ~^TX_DATA, TX_DATA};
  end

  // Control state register and registered outputs
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      edge_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      edge_q    <= edge_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      nack_q    <= nack_d;
    end
  end

  // Next-state logic: sequencing, bit shifting, acknowledge check and timeouts
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TMR_W'(1);
    edge_d     = edge_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    nack_d     = nack_q;
    load_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        edge_d    = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        // a request coinciding with the completion pulse is dropped
        if (TX_START && !done_q && !err_q) begin
          state_d    = INHIBIT;
          clk_oe_d   = 1'b1;
          load_frame = 1'b1;
        end
      end
      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          state_d   = REQ;
          data_oe_d = 1'b1;
          timer_d   = '0;
        end
      end
      REQ: begin
        if (timer_q == REQ_LAST) begin
          state_d  = SEND;
          clk_oe_d = 1'b0;
          timer_d  = '0;
          edge_d   = '0;
        end
      end
      SEND: begin
        if (clk_fall) begin
          timer_d   = '0;
          edge_d    = edge_q + 4'd1;
          data_oe_d = ~frame_q[edge_q];
          // the tenth edge places the stop bit, which releases the line
          if (edge_q == 4'd9) state_d = ACK;
        end else if ((edge_q == 4'd0) ? (timer_q == FIRST_LAST) : (timer_q == BIT_LAST)) begin
          state_d   = IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      ACK: begin
        if (clk_fall) begin
          nack_d  = dat_flt;
          timer_d = '0;
          state_d = WAIT_IDLE;
        end else if (timer_q == BIT_LAST) begin
          state_d   = IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_flt && dat_flt) begin
          state_d   = IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = ~nack_q;
          err_d     = nack_q;
        end else if (timer_q == BIT_LAST) begin
          state_d   = IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  assign TX_BUSY     = (state_q != IDLE);
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;

endmodule
